// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths and FSM encoding for the memory-side controller.
package mem_ctrl_pkg;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_e;
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: cache-facing request port and backing-memory req/ack bus.
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] cache_wb_data;
   logic [DATA_W-1:0] mem_data;
   logic              mem_read_fin;
   logic              mem_write_fin;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_err;
   modport slave (
      input  mem_rd, mem_wr, mem_addr, cache_wb_data, bus_ack, bus_rdata,
      output mem_data, mem_read_fin, mem_write_fin, bus_req, bus_we, bus_addr, bus_wdata, bus_err
   );
   modport master (
      output mem_rd, mem_wr, mem_addr, cache_wb_data, bus_ack, bus_rdata,
      input  mem_data, mem_read_fin, mem_write_fin, bus_req, bus_we, bus_addr, bus_wdata, bus_err
   );
endinterface

// File: rtl/mem_wbuf.sv
// mem_wbuf: one-entry posted write-back buffer with address-match compare.
module mem_wbuf
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              hit_o
);
   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= cap_i ? 1'b1 : clr_i ? 1'b0 : valid_q;
         addr_q  <= cap_i ? addr_i : addr_q;
         data_q  <= cap_i ? data_i : data_q;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign hit_o   = valid_q && (addr_q == cmp_addr_i);
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: posts cache write-backs into a one-entry buffer, forwards matching
// reads from it, and issues single-outstanding req/ack bus transactions with timeout.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input logic       clk,
   input logic       rst_n,
   mem_ctrl_if.slave mem_if
);
   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              rfin_q;
   logic              wfin_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic              wb_valid;
   logic              wb_hit;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              cap;
   logic              clr;
   logic              tmo;
   logic              done;

   assign cap  = (state_q == IDLE) && mem_if.mem_wr && !wb_valid;
   assign tmo  = cnt_q == CNT_W'(TIMEOUT - 1);
   assign done = mem_if.bus_ack || tmo;
   // an aborted drain discards the buffered write just like a completed one
   assign clr  = (state_q == DRAIN) && done;

   mem_wbuf u_wbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_i     (cap),
      .clr_i     (clr),
      .addr_i    (mem_if.mem_addr),
      .data_i    (mem_if.cache_wb_data),
      .cmp_addr_i(mem_if.mem_addr),
      .valid_o   (wb_valid),
      .addr_o    (wb_addr),
      .data_o    (wb_data),
      .hit_o     (wb_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_data_q <= '0;
         rfin_q     <= 1'b0;
         wfin_q     <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         rfin_q <= 1'b0;
         wfin_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cap) begin
                  wfin_q <= 1'b1;
               end else if (mem_if.mem_rd && wb_hit) begin
                  mem_data_q <= wb_data;
                  rfin_q     <= 1'b1;
                  state_q    <= RESP;
               end else if (wb_valid) begin
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= wb_addr;
                  wdata_q <= wb_data;
                  cnt_q   <= '0;
                  state_q <= DRAIN;
               end else if (mem_if.mem_rd) begin
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= mem_if.mem_addr;
                  cnt_q   <= '0;
                  state_q <= READ;
               end
            end
            DRAIN: begin
               if (done) begin
                  req_q   <= 1'b0;
                  err_q   <= err_q || !mem_if.bus_ack;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            READ: begin
               if (done) begin
                  req_q      <= 1'b0;
                  err_q      <= err_q || !mem_if.bus_ack;
                  mem_data_q <= mem_if.bus_ack ? mem_if.bus_rdata : '0;
                  rfin_q     <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: state_q <= IDLE;
         endcase
      end
   end

   assign mem_if.mem_data      = mem_data_q;
   assign mem_if.mem_read_fin  = rfin_q;
   assign mem_if.mem_write_fin = wfin_q;
   assign mem_if.bus_req       = req_q;
   assign mem_if.bus_we        = we_q;
   assign mem_if.bus_addr      = addr_q;
   assign mem_if.bus_wdata     = wdata_q;
   assign mem_if.bus_err       = err_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of reads, forwarding, drains, timeout and async reset.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic              s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;

   mem_ctrl_if m_if();

   mem_ctrl #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mem_if(m_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // waits for bus_req, records the transaction, acks after lat extra edges
   task automatic serve(input int lat, input logic [DATA_W-1:0] rd,
                        output logic we, output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] wd);
      int n = 0;
      while (!m_if.bus_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", 64'(m_if.bus_req), 64'd1);
      we = m_if.bus_we;
      a  = m_if.bus_addr;
      wd = m_if.bus_wdata;
      repeat (lat) tick();
      m_if.bus_ack   = 1'b1;
      m_if.bus_rdata = rd;
      tick();
      m_if.bus_ack = 1'b0;
   endtask

   initial begin
      m_if.mem_rd = 1'b0;
      m_if.mem_wr = 1'b0;
      m_if.mem_addr = '0;
      m_if.cache_wb_data = '0;
      m_if.bus_ack = 1'b0;
      m_if.bus_rdata = '0;
      repeat (2) tick();
      chk("rst_mem_data", 64'(m_if.mem_data), 64'd0);
      chk("rst_rfin", 64'(m_if.mem_read_fin), 64'd0);
      chk("rst_wfin", 64'(m_if.mem_write_fin), 64'd0);
      chk("rst_req", 64'(m_if.bus_req), 64'd0);
      chk("rst_we", 64'(m_if.bus_we), 64'd0);
      chk("rst_addr", 64'(m_if.bus_addr), 64'd0);
      chk("rst_err", 64'(m_if.bus_err), 64'd0);
      rst_n = 1'b1;
      tick();

      m_if.mem_rd = 1'b1;
      m_if.mem_addr = 30'd0;
      tick();
      chk("rd_req", 64'(m_if.bus_req), 64'd1);
      chk("rd_we", 64'(m_if.bus_we), 64'd0);
      chk("rd_addr", 64'(m_if.bus_addr), 64'd0);
      tick();
      tick();
      chk("rd_fin_early", 64'(m_if.mem_read_fin), 64'd0);
      m_if.bus_ack = 1'b1;
      m_if.bus_rdata = 32'h12345678;
      tick();
      m_if.bus_ack = 1'b0;
      chk("rd_fin", 64'(m_if.mem_read_fin), 64'd1);
      chk("rd_data", 64'(m_if.mem_data), 64'h12345678);
      chk("rd_req_drop", 64'(m_if.bus_req), 64'd0);
      m_if.mem_rd = 1'b0;
      tick();
      chk("rd_fin_pulse", 64'(m_if.mem_read_fin), 64'd0);
      chk("rd_data_hold", 64'(m_if.mem_data), 64'h12345678);

      m_if.mem_wr = 1'b1;
      m_if.mem_addr = 30'd1;
      m_if.cache_wb_data = 32'h87654321;
      tick();
      chk("fw_wfin", 64'(m_if.mem_write_fin), 64'd1);
      chk("fw_no_req0", 64'(m_if.bus_req), 64'd0);
      m_if.mem_wr = 1'b0;
      m_if.mem_rd = 1'b1;
      tick();
      chk("fw_rfin", 64'(m_if.mem_read_fin), 64'd1);
      chk("fw_data", 64'(m_if.mem_data), 64'h87654321);
      chk("fw_no_req1", 64'(m_if.bus_req), 64'd0);
      chk("fw_wfin_pulse", 64'(m_if.mem_write_fin), 64'd0);
      m_if.mem_rd = 1'b0;
      tick();
      serve(0, 32'h0, s_we, s_addr, s_wdata);
      chk("fw_drain_we", 64'(s_we), 64'd1);
      chk("fw_drain_addr", 64'(s_addr), 64'd1);
      chk("fw_drain_data", 64'(s_wdata), 64'h87654321);

      m_if.mem_wr = 1'b1;
      m_if.mem_addr = 30'd1;
      m_if.cache_wb_data = 32'hAAAA5555;
      tick();
      chk("mm_wfin", 64'(m_if.mem_write_fin), 64'd1);
      m_if.mem_wr = 1'b0;
      m_if.mem_rd = 1'b1;
      m_if.mem_addr = 30'd1024;
      serve(1, 32'h0, s_we, s_addr, s_wdata);
      chk("mm_wr_we", 64'(s_we), 64'd1);
      chk("mm_wr_addr", 64'(s_addr), 64'd1);
      chk("mm_wr_data", 64'(s_wdata), 64'hAAAA5555);
      serve(1, 32'hCAFEF00D, s_we, s_addr, s_wdata);
      chk("mm_rd_we", 64'(s_we), 64'd0);
      chk("mm_rd_addr", 64'(s_addr), 64'd1024);
      chk("mm_rfin", 64'(m_if.mem_read_fin), 64'd1);
      chk("mm_data", 64'(m_if.mem_data), 64'hCAFEF00D);
      chk("mm_wb_empty", 64'(dut.u_wbuf.valid_o), 64'd0);
      m_if.mem_rd = 1'b0;
      tick();

      m_if.mem_wr = 1'b1;
      m_if.mem_addr = 30'd5;
      m_if.cache_wb_data = 32'h11111111;
      tick();
      chk("bb_wfin1", 64'(m_if.mem_write_fin), 64'd1);
      m_if.mem_addr = 30'd6;
      m_if.cache_wb_data = 32'h22222222;
      serve(2, 32'h0, s_we, s_addr, s_wdata);
      chk("bb_w1_we", 64'(s_we), 64'd1);
      chk("bb_w1_addr", 64'(s_addr), 64'd5);
      chk("bb_w1_data", 64'(s_wdata), 64'h11111111);
      chk("bb_wfin_held", 64'(m_if.mem_write_fin), 64'd0);
      tick();
      chk("bb_wfin2", 64'(m_if.mem_write_fin), 64'd1);
      m_if.mem_wr = 1'b0;
      serve(0, 32'h0, s_we, s_addr, s_wdata);
      chk("bb_w2_we", 64'(s_we), 64'd1);
      chk("bb_w2_addr", 64'(s_addr), 64'd6);
      chk("bb_w2_data", 64'(s_wdata), 64'h22222222);
      tick();

      m_if.mem_rd = 1'b1;
      m_if.mem_addr = 30'd77;
      tick();
      chk("to_req_start", 64'(m_if.bus_req), 64'd1);
      repeat (7) tick();
      chk("to_req_held", 64'(m_if.bus_req), 64'd1);
      chk("to_err_early", 64'(m_if.bus_err), 64'd0);
      tick();
      chk("to_req_drop", 64'(m_if.bus_req), 64'd0);
      chk("to_err", 64'(m_if.bus_err), 64'd1);
      chk("to_rfin", 64'(m_if.mem_read_fin), 64'd1);
      chk("to_data", 64'(m_if.mem_data), 64'd0);
      m_if.mem_rd = 1'b0;
      tick();
      chk("to_err_sticky", 64'(m_if.bus_err), 64'd1);
      m_if.bus_ack = 1'b1;
      tick();
      m_if.bus_ack = 1'b0;
      chk("late_ack_req", 64'(m_if.bus_req), 64'd0);
      chk("late_ack_rfin", 64'(m_if.mem_read_fin), 64'd0);

      m_if.mem_wr = 1'b1;
      m_if.mem_addr = 30'd9;
      m_if.cache_wb_data = 32'h99999999;
      tick();
      m_if.mem_wr = 1'b0;
      tick();
      chk("rs_drain_req", 64'(m_if.bus_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_req_async", 64'(m_if.bus_req), 64'd0);
      chk("rs_wb_async", 64'(dut.u_wbuf.valid_o), 64'd0);
      chk("rs_err_clr", 64'(m_if.bus_err), 64'd0);
      tick();
      rst_n = 1'b1;
      chk("rs_idle", 64'(dut.state_q), 64'(IDLE));
      m_if.mem_rd = 1'b1;
      m_if.mem_addr = 30'd9;
      tick();
      chk("rs_rd_req", 64'(m_if.bus_req), 64'd1);
      chk("rs_rd_we", 64'(m_if.bus_we), 64'd0);
      chk("rs_rd_addr", 64'(m_if.bus_addr), 64'd9);
      serve(0, 32'h0000BEEF, s_we, s_addr, s_wdata);
      chk("rs_rfin", 64'(m_if.mem_read_fin), 64'd1);
      chk("rs_data", 64'(m_if.mem_data), 64'h0000BEEF);
      m_if.mem_rd = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
